// File: rtl/mesi_pkg.sv
// mesi_pkg: instruction field layout, processor-id encoding and issue FSM states
package mesi_pkg;
  localparam int INSTR_W = 16;
  localparam int WR_BIT = 15;
  localparam int PID_HI = 14;
  localparam int PID_LO = 13;
  localparam int TAG_HI = 12;
  localparam int TAG_LO = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;
  localparam int RES_W = 8;
  localparam int CNT_W = 8;
  localparam int HOLD_W = 4;
  localparam logic [1:0] PROC_NONE = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_CAPTURE} state_t;

  function automatic logic [1:0] proc_id(input logic [INSTR_W-1:0] instr);
    return instr[PID_HI:PID_LO];
  endfunction
endpackage

// File: rtl/mesi_instr_fifo.sv
// mesi_instr_fifo: synchronous instruction FIFO with occupancy count
module mesi_instr_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  // full blocks the push even when a pop frees a slot in the same cycle
  assign full = count_q == FULL_CNT;
  assign do_push = push && !full;
  assign do_pop = pop && count_q != '0;
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = (do_push && !do_pop) ? count_q + 1'b1 :
              (!do_push && do_pop) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/mesi_issue_queue.sv
// mesi_issue_queue: buffers instructions and issues them one at a time to a MESI coherence controller
module mesi_issue_queue
  import mesi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic [INSTR_W-1:0] instrucao,
  output logic               hab_escrita_mem,
  input  logic [RES_W-1:0]   saida_in,
  output logic               res_valid,
  output logic [RES_W-1:0]   res_data,
  output logic [INSTR_W-1:0] res_instr,
  output logic               busy,
  output logic [CNT_W-1:0]   issue_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  state_t state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [INSTR_W-1:0] instrucao_q, instrucao_d, res_instr_q, res_instr_d, head;
  logic [RES_W-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d, drop_cnt_q, drop_cnt_d;
  logic hab_q, hab_d, res_valid_q, res_valid_d;
  logic [$clog2(DEPTH):0] fifo_count;
  logic fifo_full, pop, start, drop;

  mesi_instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_instr),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign pop = state_q == S_IDLE && fifo_count != '0;
  assign start = pop && proc_id(head) != PROC_NONE;
  assign drop = pop && proc_id(head) == PROC_NONE;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == S_IDLE ? (start ? S_ISSUE : S_IDLE) :
              state_q == S_ISSUE ? S_HOLD :
              state_q == S_HOLD ? (hold_q == '0 ? S_CAPTURE : S_HOLD) : S_IDLE;
  end

  // dropped words consume their pop cycle but leave the controller interface untouched
  always_comb begin
    instrucao_d = start ? head : state_q inside {S_IDLE, S_CAPTURE} ? '0 : instrucao_q;
    hab_d = start;
    hold_d = state_q == S_ISSUE ? HOLD_LAST : state_q == S_HOLD ? hold_q - 1'b1 : hold_q;
    issue_cnt_d = state_q == S_ISSUE ? issue_cnt_q + 1'b1 : issue_cnt_q;
    drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    res_valid_d = state_q == S_CAPTURE;
    res_data_d = state_q == S_CAPTURE ? saida_in : res_data_q;
    res_instr_d = state_q == S_CAPTURE ? instrucao_q : res_instr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      instrucao_q <= '0;
      hab_q <= 1'b0;
      issue_cnt_q <= '0;
      drop_cnt_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_instr_q <= '0;
    end else begin
      hold_q <= hold_d;
      instrucao_q <= instrucao_d;
      hab_q <= hab_d;
      issue_cnt_q <= issue_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      res_instr_q <= res_instr_d;
    end
  end

  assign in_ready = !fifo_full;
  assign instrucao = instrucao_q;
  assign hab_escrita_mem = hab_q;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign res_instr = res_instr_q;
  assign issue_cnt = issue_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign busy = state_q != S_IDLE || fifo_count != '0;
endmodule

// File: tb/tb_mesi_issue_queue.sv
// tb_mesi_issue_queue: directed checks of issue timing, capture, drops, backpressure and reset abort
module tb_mesi_issue_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic in_ready;
  logic [15:0] instrucao;
  logic hab_escrita_mem;
  logic [7:0] saida_in;
  logic [7:0] saida_man = '0;
  logic auto_resp = 1'b0;
  logic res_valid;
  logic [7:0] res_data;
  logic [15:0] res_instr;
  logic busy;
  logic [7:0] issue_cnt;
  logic [7:0] drop_cnt;
  int errors = 0;
  int checks = 0;
  logic [15:0] got_instr [$];
  logic [7:0] got_data [$];
  logic [15:0] items [11];

  always #5 clk = ~clk;

  // in auto mode the bench plays a controller whose answer is derived from the issued word
  assign saida_in = auto_resp ? (instrucao[7:0] ^ 8'hA5) : saida_man;

  mesi_issue_queue #(.DEPTH(8), .HOLD_CYCLES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_instr        (in_instr),
    .in_ready        (in_ready),
    .instrucao       (instrucao),
    .hab_escrita_mem (hab_escrita_mem),
    .saida_in        (saida_in),
    .res_valid       (res_valid),
    .res_data        (res_data),
    .res_instr       (res_instr),
    .busy            (busy),
    .issue_cnt       (issue_cnt),
    .drop_cnt        (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (res_valid) begin
      got_instr.push_back(res_instr);
      got_data.push_back(res_data);
    end
  endtask

  task automatic push(input logic [15:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_instr", 32'(instrucao), 32'h0);
    check("rst_hab", 32'(hab_escrita_mem), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data", 32'(res_data), 32'h0);
    check("rst_res_instr", 32'(res_instr), 32'h0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // write 0xA13C: pop edge, ISSUE, two HOLD cycles, CAPTURE, result
    saida_man = 8'h5A;
    push(16'hA13C);
    check("w_queued_hab", 32'(hab_escrita_mem), 32'h0);
    check("w_queued_busy", 32'(busy), 32'h1);
    tick();
    check("w_issue_hab", 32'(hab_escrita_mem), 32'h1);
    check("w_issue_instr", 32'(instrucao), 32'hA13C);
    tick();
    check("w_hold1_hab", 32'(hab_escrita_mem), 32'h0);
    check("w_hold1_instr", 32'(instrucao), 32'hA13C);
    check("w_issue_cnt", 32'(issue_cnt), 32'h1);
    tick();
    check("w_hold2_instr", 32'(instrucao), 32'hA13C);
    tick();
    check("w_capt_instr", 32'(instrucao), 32'hA13C);
    check("w_capt_no_valid", 32'(res_valid), 32'h0);
    tick();
    check("w_res_valid", 32'(res_valid), 32'h1);
    check("w_res_data", 32'(res_data), 32'h5A);
    check("w_res_instr", 32'(res_instr), 32'hA13C);
    check("w_instr_cleared", 32'(instrucao), 32'h0);
    tick();
    check("w_valid_pulse", 32'(res_valid), 32'h0);
    check("w_res_hold", 32'(res_instr), 32'hA13C);

    // read 0x4155: only the value present during CAPTURE is taken
    saida_man = 8'h00;
    push(16'h4155);
    repeat (4) tick();
    check("r_capt_hab", 32'(hab_escrita_mem), 32'h0);
    saida_man = 8'h77;
    tick();
    check("r_res_valid", 32'(res_valid), 32'h1);
    check("r_res_data", 32'(res_data), 32'h77);
    check("r_res_instr", 32'(res_instr), 32'h4155);
    check("r_issue_cnt", 32'(issue_cnt), 32'h2);
    saida_man = 8'h00;
    tick();
    check("r_res_data_hold", 32'(res_data), 32'h77);

    // proc id 00 is dropped without touching the controller
    push(16'h0012);
    tick();
    check("d_drop_cnt", 32'(drop_cnt), 32'h1);
    check("d_hab", 32'(hab_escrita_mem), 32'h0);
    check("d_instr", 32'(instrucao), 32'h0);
    check("d_busy", 32'(busy), 32'h0);
    check("d_issue_cnt", 32'(issue_cnt), 32'h2);

    // back-to-back stream: queue fills after the 10th word, the 11th waits two cycles
    got_instr.delete();
    got_data.delete();
    auto_resp = 1'b1;
    for (int i = 0; i < 11; i++)
      items[i] = {1'(i & 1), 2'(i % 3 + 1), 5'(i), 8'(i * 37 + 5)};
    for (int i = 0; i < 11; i++) begin
      int waits = 0;
      in_valid = 1'b1;
      in_instr = items[i];
      while (!in_ready && waits < 20) begin
        tick();
        waits++;
      end
      if (i == 10) check("f_full_wait", 32'(waits), 32'd2);
      tick();
      check($sformatf("f_ready_%0d", i + 1), 32'(in_ready), 32'(i + 1 < 10));
    end
    in_valid = 1'b0;
    for (int n = 0; n < 200 && got_instr.size() < 11; n++) tick();
    check("f_result_count", 32'(got_instr.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < got_instr.size()) begin
        check($sformatf("f_instr_%0d", i), 32'(got_instr[i]), 32'(items[i]));
        check($sformatf("f_data_%0d", i), 32'(got_data[i]), 32'(items[i][7:0] ^ 8'hA5));
      end
    check("f_issue_cnt", 32'(issue_cnt), 32'd13);
    check("f_busy_done", 32'(busy), 32'h0);

    // reset during HOLD with three words queued behind the active one
    got_instr.delete();
    got_data.delete();
    push(16'h2101);
    push(16'hC202);
    push(16'h4303);
    push(16'hE404);
    check("x_hold_instr", 32'(instrucao), 32'h2101);
    check("x_hold_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("x_instr", 32'(instrucao), 32'h0);
    check("x_hab", 32'(hab_escrita_mem), 32'h0);
    check("x_in_ready", 32'(in_ready), 32'h1);
    check("x_issue_cnt", 32'(issue_cnt), 32'h0);
    check("x_drop_cnt", 32'(drop_cnt), 32'h0);
    check("x_res_instr", 32'(res_instr), 32'h0);
    repeat (12) tick();
    check("x_no_results", 32'(got_instr.size()), 32'd0);
    check("x_busy", 32'(busy), 32'h0);

    // drop counter saturates
    for (int i = 0; i < 200; i++) push(16'h1F00 | 16'(i));
    tick();
    tick();
    check("s_drop_200", 32'(drop_cnt), 32'd200);
    for (int i = 0; i < 100; i++) push(16'h1F00 | 16'(i));
    tick();
    tick();
    check("s_drop_sat", 32'(drop_cnt), 32'd255);
    check("s_issue_cnt", 32'(issue_cnt), 32'd0);
    check("s_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
